// File: rtl/aes_inv_sbox_arb.sv
// Round-robin sequencer sharing one 32-bit inverse S-box word instance
// between two 128-bit InvSubBytes requesters, one word per cycle.
module aes_inv_sbox_arb #(
  parameter int unsigned PIPE = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req0_valid,
  output logic         o_req0_ready,
  input  logic [127:0] i_req0_state,
  output logic         o_rsp0_valid,
  input  logic         i_rsp0_ready,
  output logic [127:0] o_rsp0_state,
  input  logic         i_req1_valid,
  output logic         o_req1_ready,
  input  logic [127:0] i_req1_state,
  output logic         o_rsp1_valid,
  input  logic         i_rsp1_ready,
  output logic [127:0] o_rsp1_state,
  output logic [31:0]  o_sbox_word,
  input  logic [31:0]  i_sbox_word,
  output logic         o_busy,
  output logic         o_grant_id
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned WORD_W  = 32;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, RESP} state_e;

  state_e               state_q, state_d;
  logic [1:0]           k_q;
  logic                 grant_q, last_q;
  logic [STATE_W-1:0]   req_q, res_q, res_d, rsp0_q, rsp1_q;
  logic [WORD_W-1:0]    pipe_q;
  logic [1:0]           pipe_k_q;
  logic                 pipe_v_q;
  logic                 win0, win1, acc0, acc1, accept, rsp_hs, load_rsp;

  // Word 0 is the most significant 32 bits of the state.
  function automatic logic [WORD_W-1:0] get_word(input logic [STATE_W-1:0] v,
                                                 input logic [1:0] idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = v[127:96];
      2'd1:    w = v[95:64];
      2'd2:    w = v[63:32];
      default: w = v[31:0];
    endcase
    return w;
  endfunction

  function automatic logic [STATE_W-1:0] put_word(input logic [STATE_W-1:0] v,
                                                  input logic [1:0] idx,
                                                  input logic [WORD_W-1:0] w);
    logic [STATE_W-1:0] r;
    r = v;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  // Arbitration: a lone requester wins; under contention the one not granted last wins.
  always_comb begin
    win0     = i_req0_valid & (~i_req1_valid | last_q);
    win1     = i_req1_valid & (~i_req0_valid | ~last_q);
    acc0     = (state_q == IDLE) & win0;
    acc1     = (state_q == IDLE) & win1;
    accept   = acc0 | acc1;
    rsp_hs   = (state_q == RESP) & (grant_q ? i_rsp1_ready : i_rsp0_ready);
    load_rsp = (state_d == RESP) & (state_q != RESP);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FEED;
      FEED:    if (k_q == 2'd3) state_d = (PIPE != 0) ? DRAIN : RESP;
      DRAIN:   state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    o_req0_ready = acc0;
    o_req1_ready = acc1;
    o_busy       = (state_q != IDLE);
    o_rsp0_valid = (state_q == RESP) & ~grant_q;
    o_rsp1_valid = (state_q == RESP) & grant_q;
    o_sbox_word  = '0;
    if (state_q == FEED) o_sbox_word = get_word(req_q, k_q);
  end

  // Result merge: direct S-box word, or the word registered one cycle earlier.
  always_comb begin
    res_d = res_q;
    if (PIPE == 0) begin
      if (state_q == FEED) res_d = put_word(res_q, k_q, i_sbox_word);
    end else begin
      if (pipe_v_q) res_d = put_word(res_q, pipe_k_q, pipe_q);
    end
  end

  // Datapath: request latch, word counter, accumulator and per-requester results.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      k_q      <= 2'd0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      req_q    <= '0;
      res_q    <= '0;
      rsp0_q   <= '0;
      rsp1_q   <= '0;
      pipe_q   <= '0;
      pipe_k_q <= 2'd0;
      pipe_v_q <= 1'b0;
    end else begin
      if (accept) begin
        req_q   <= acc1 ? i_req1_state : i_req0_state;
        grant_q <= acc1;
        last_q  <= acc1;
        k_q     <= 2'd0;
        res_q   <= '0;
      end else begin
        if (state_q == FEED) k_q <= k_q + 2'd1;
        res_q <= res_d;
      end
      pipe_q   <= i_sbox_word;
      pipe_k_q <= k_q;
      pipe_v_q <= (state_q == FEED);
      if (load_rsp && !grant_q) rsp0_q <= res_d;
      if (load_rsp && grant_q)  rsp1_q <= res_d;
    end
  end

  assign o_rsp0_state = rsp0_q;
  assign o_rsp1_state = rsp1_q;
  assign o_grant_id   = grant_q;

endmodule

// File: tb/tb_aes_inv_sbox_arb.sv
// Bench for aes_inv_sbox_arb: PIPE=0 instance checked throughout, PIPE=1 instance on one request.
module tb_aes_inv_sbox_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, v0, v1, rr0, rr1;
  logic [127:0] s0, s1;
  logic         rdy0, rdy1, rv0, rv1, busy, gid;
  logic [127:0] rs0, rs1;
  logic [31:0]  sbw, sbi;
  logic         rdy0_p, rdy1_p, rv0_p, rv1_p, busy_p, gid_p;
  logic [127:0] rs0_p, rs1_p;
  logic [31:0]  sbw_p, sbi_p;

  typedef struct { logic id; logic [127:0] data; } exp_t;
  exp_t sb_q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Inverse S-box model: inverse affine transform followed by GF(2^8) inversion.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int x = 1; x < 256; x++)
      if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
    return 8'h00;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction

  function automatic logic [31:0] inv_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = inv_sbox(w[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] inv_state(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = inv_word(v[32*i +: 32]);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  assign sbi   = inv_word(sbw);
  assign sbi_p = inv_word(sbw_p);

  aes_inv_sbox_arb #(.PIPE(0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_state(s0),
    .o_rsp0_valid(rv0), .i_rsp0_ready(rr0), .o_rsp0_state(rs0),
    .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_state(s1),
    .o_rsp1_valid(rv1), .i_rsp1_ready(rr1), .o_rsp1_state(rs1),
    .o_sbox_word(sbw), .i_sbox_word(sbi), .o_busy(busy), .o_grant_id(gid)
  );

  aes_inv_sbox_arb #(.PIPE(1)) dut_p (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(rdy0_p), .i_req0_state(s0),
    .o_rsp0_valid(rv0_p), .i_rsp0_ready(rr0), .o_rsp0_state(rs0_p),
    .i_req1_valid(v1), .o_req1_ready(rdy1_p), .i_req1_state(s1),
    .o_rsp1_valid(rv1_p), .i_rsp1_ready(rr1), .o_rsp1_state(rs1_p),
    .o_sbox_word(sbw_p), .i_sbox_word(sbi_p), .o_busy(busy_p), .o_grant_id(gid_p)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return rdy0;
      1:       return rdy1;
      2:       return rv0;
      3:       return rv1;
      4:       return !busy;
      default: return rdy0 | rdy1;
    endcase
  endfunction

  task automatic wait_for(input int which, input string tag);
    int cnt;
    cnt = 0;
    while (!cond(which) && cnt < 50) begin
      tick();
      cnt++;
    end
    check_eq(tag, 128'(cond(which)), 128'd1);
  endtask

  task automatic pop_check(input logic id, input logic [127:0] data);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("rsp_unexpected", 128'd1, 128'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("rsp_id", 128'(id), 128'(e.id));
      check_eq("rsp_data", data, e.data);
    end
  endtask

  // Scoreboard: push expected on accept, pop and compare on response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("one_ready", 128'(rdy0 & rdy1), 128'd0);
      if (v0 && rdy0) sb_q.push_back('{id: 1'b0, data: inv_state(s0)});
      if (v1 && rdy1) sb_q.push_back('{id: 1'b1, data: inv_state(s1)});
      if (rv0 && rr0) pop_check(1'b0, rs0);
      if (rv1 && rr1) pop_check(1'b1, rs1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  tw [4];
    logic [127:0] e;
    tw = '{32'h63636363, 32'h7c7c7c7c, 32'h00000000, 32'hffffffff};
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; s0 = '0; s1 = '0; rr0 = 1'b0; rr1 = 1'b0;
    tick();
    tick();
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_gid", 128'(gid), 128'd0);
    check_eq("rst_rv", 128'({rv0, rv1}), 128'd0);
    check_eq("rst_rs0", rs0, 128'd0);
    check_eq("rst_rs1", rs1, 128'd0);
    check_eq("rst_sbw", 128'(sbw), 128'd0);
    check_eq("rst_busy_p", 128'(busy_p), 128'd0);
    rst = 1'b0;

    // Single request on both PIPE variants.
    s0 = 128'h63636363_7c7c7c7c_00000000_ffffffff;
    v0 = 1'b1;
    rr0 = 1'b1;
    #1;
    check_eq("t1_ready0", 128'(rdy0), 128'd1);
    check_eq("t1_sbw_idle", 128'(sbw), 128'd0);
    tick();
    v0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq("t1_sbw", 128'(sbw), 128'(tw[k]));
      check_eq("t1_sbw_p", 128'(sbw_p), 128'(tw[k]));
      tick();
    end
    check_eq("t1_rv0", 128'(rv0), 128'd1);
    check_eq("t1_rs0", rs0, 128'h00000000_01010101_52525252_7d7d7d7d);
    check_eq("t1_sbw_after", 128'(sbw), 128'd0);
    check_eq("t1_rv0_p_drain", 128'(rv0_p), 128'd0);
    check_eq("t1_busy_p_drain", 128'(busy_p), 128'd1);
    tick();
    check_eq("t1_idle", 128'(busy), 128'd0);
    check_eq("t1_rv0_p", 128'(rv0_p), 128'd1);
    check_eq("t1_rs0_p", rs0_p, 128'h00000000_01010101_52525252_7d7d7d7d);
    tick();
    check_eq("t1_idle_p", 128'(busy_p), 128'd0);

    // Contention right after reset: grants alternate 0,1,0,1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    s0 = rnd128(); s1 = rnd128();
    v0 = 1'b1; v1 = 1'b1; rr0 = 1'b1; rr1 = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      wait_for(5, "arb_wait");
      check_eq("arb_winner", 128'(rdy1), 128'(g % 2));
      tick();
      check_eq("arb_gid", 128'(gid), 128'(g % 2));
      if (gid) s1 = rnd128();
      else     s0 = rnd128();
    end
    v0 = 1'b0; v1 = 1'b0;
    wait_for(4, "arb_drain");
    tick();
    check_eq("arb_sb_empty", 128'(sb_q.size()), 128'd0);

    // Back-pressure with stray rsp1_ready and a pending req1.
    rr0 = 1'b0; rr1 = 1'b0;
    s0 = rnd128();
    e = inv_state(s0);
    v0 = 1'b1;
    #1;
    wait_for(0, "bp_ready0");
    tick();
    v0 = 1'b0;
    wait_for(2, "bp_rv0");
    v1 = 1'b1;
    s1 = rnd128();
    #1;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_rv0", 128'(rv0), 128'd1);
      check_eq("bp_rs0", rs0, e);
      check_eq("bp_busy", 128'(busy), 128'd1);
      check_eq("bp_readies", 128'({rdy0, rdy1}), 128'd0);
      check_eq("bp_rv1", 128'(rv1), 128'd0);
      rr1 = (i >= 3 && i <= 5);
      tick();
    end
    rr1 = 1'b0;
    rr0 = 1'b1;
    tick();
    check_eq("bp_idle", 128'(busy), 128'd0);
    check_eq("bp_rs0_hold", rs0, e);
    check_eq("bp_ready1", 128'(rdy1), 128'd1);
    tick();
    v1 = 1'b0;
    rr1 = 1'b1;
    check_eq("bp_gid1", 128'(gid), 128'd1);
    wait_for(4, "bp_drain");
    tick();
    check_eq("bp_sb_empty", 128'(sb_q.size()), 128'd0);

    // req1 valid dropped before ready has no effect.
    s0 = rnd128();
    v0 = 1'b1;
    #1;
    wait_for(0, "drop_ready0");
    tick();
    v0 = 1'b0;
    v1 = 1'b1;
    s1 = rnd128();
    tick();
    tick();
    v1 = 1'b0;
    wait_for(4, "drop_drain");
    for (int i = 0; i < 3; i++) begin
      check_eq("drop_busy", 128'(busy), 128'd0);
      check_eq("drop_gid", 128'(gid), 128'd0);
      tick();
    end
    check_eq("drop_sb_empty", 128'(sb_q.size()), 128'd0);

    // Reset in the middle of FEED discards the request.
    s0 = rnd128();
    v0 = 1'b1;
    #1;
    wait_for(0, "mid_ready0");
    tick();
    v0 = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("mid_busy", 128'(busy), 128'd0);
    check_eq("mid_gid", 128'(gid), 128'd0);
    check_eq("mid_rv", 128'({rv0, rv1}), 128'd0);
    check_eq("mid_rs0", rs0, 128'd0);
    check_eq("mid_rs1", rs1, 128'd0);
    check_eq("mid_sbw", 128'(sbw), 128'd0);
    sb_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq("mid_no_rsp", 128'({rv0, rv1, busy}), 128'd0);
      tick();
    end
    s1 = rnd128();
    v1 = 1'b1;
    rr1 = 1'b1;
    #1;
    wait_for(1, "mid_ready1");
    tick();
    v1 = 1'b0;
    check_eq("mid_gid1", 128'(gid), 128'd1);
    wait_for(3, "mid_rv1");
    tick();
    wait_for(4, "mid_drain");
    tick();
    check_eq("mid_sb_empty", 128'(sb_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_inv_sbox_arb.md
# aes_inv_sbox_arb

Round-robin arbiter and sequencer that time-shares one 32-bit `aes_inv_sbox` word instance between two 128-bit InvSubBytes requesters, for example two decryption lanes. For each request it accepts a full 128-bit state and feeds the four 32-bit words through the shared S-box, one word per cycle. It then reassembles the 128-bit result and returns it on a per-requester response handshake. The block sits between the decryption round logic and the single combinational inverse S-box.

## Interface
Parameters:
- `PIPE`, 0: 0 = S-box output captured in the same cycle the word is presented; 1 = one register stage between the S-box output and the result accumulator, for timing closure.

Ports:
- `i_clk`  in  1  single clock; all logic is on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req0_valid`  in  1  requester 0 has a state to substitute.
- `o_req0_ready`  out  1  requester 0 is accepted this cycle.
- `i_req0_state`  in  128  requester 0 input state.
- `o_rsp0_valid`  out  1  requester 0 result is available.
- `i_rsp0_ready`  in  1  requester 0 consumes the result.
- `o_rsp0_state`  out  128  requester 0 InvSubBytes result.
- `i_req1_valid`, `o_req1_ready`, `i_req1_state`, `o_rsp1_valid`, `i_rsp1_ready`, `o_rsp1_state`: same as requester 0, for requester 1.
- `o_sbox_word`  out  32  word driven to the S-box input `i_inv_wrd_sbox`.
- `i_sbox_word`  in  32  word returned from the S-box output `o_inv_wrd_sbox`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_grant_id`  out  1  id of the request currently owned; holds its last value while in IDLE.

## Operation
- FSM states: IDLE, FEED, DRAIN, RESP. DRAIN exists only when `PIPE=1`.
- **Request acceptance:**
  - A request is accepted only in IDLE.
  - `o_reqN_ready` is combinational, high in IDLE for the arbitration winner only. At most one ready is high in any cycle.
  - Accept means `i_reqN_valid & o_reqN_ready`. On accept: latch `i_reqN_state`, set `o_grant_id`, update `last_grant`, clear the word counter, go to FEED.
- **Arbitration:**
  - With one requester valid, that requester wins.
  - With both valid, the winner is the requester that is not `last_grant`.
  - `last_grant` resets to 1, so requester 0 wins the first contention.
- **FEED:**
  - 2-bit counter `k` runs 0..3.
  - `o_sbox_word` = latched word k. Word 0 is `[127:96]`, word 3 is `[31:0]`.
  - Result word k is written into the same bit slot.
  - After k=3: go to DRAIN if `PIPE=1`, otherwise RESP.
- **DRAIN:** the last registered S-box word is written into the result, then go to RESP.
- **RESP:**
  - `o_rspN_valid` is high for `N = o_grant_id` only.
  - `o_rspN_state` stays stable until `i_rspN_ready`. On that handshake, go to IDLE.
  - A new request is accepted no earlier than the following cycle.
- `o_sbox_word` = 0 outside FEED.
- `o_rspN_state` is valid only while `o_rspN_valid` is high. It holds its last value otherwise.
- Requesters hold valid and state stable until ready. The block samples the state only on the accept cycle.
- Dropping `i_reqN_valid` before ready is tolerated: no accept happens and no state changes.
- `i_rspM_ready` for the non-granted requester is ignored.

## Timing
- **Reset (sync, `i_rst` high at an edge):**
  - State = IDLE, `last_grant` = 1, counter = 0.
  - `o_busy`, `o_grant_id`, `o_rsp*_valid`, `o_rsp*_state` and `o_sbox_word` are all 0.
  - `o_req*_ready` follows the IDLE arbitration as soon as reset deasserts.
- **Reset mid-operation:** the in-flight request is discarded and no response is issued. The requester must re-issue.
- **Latency, with accept in cycle T:**
  - FEED occupies T+1..T+4, presenting words 0..3.
  - `PIPE=0`: `o_rspN_valid` rises at T+5.
  - `PIPE=1`: DRAIN at T+5, `o_rspN_valid` rises at T+6.
- **Throughput:** with the response consumed immediately, the next accept is at T+6 for `PIPE=0` and T+7 for `PIPE=1`.
- **Simultaneous events:**
  - Both valid in IDLE: exactly one is accepted.
  - A new request arriving while RESP is waiting on ready is not accepted until IDLE.

## Test plan
- Single request, `PIPE=0`:
  - Stimulus: req0 state = `0x63636363_7c7c7c7c_00000000_ffffffff`, accepted at T.
  - Required: `o_sbox_word` = `63636363`, `7c7c7c7c`, `00000000`, `ffffffff` at T+1..T+4 and 0 otherwise.
  - Required: `o_rsp0_valid` at T+5 with `0x00000000_01010101_52525252_7d7d7d7d`.
- Contention after reset:
  - Stimulus: req0 and req1 both valid in the first cycle.
  - Required: req0 accepted first, then req1 on the next IDLE, with `o_grant_id` = 0 then 1.
  - Required: sustained dual valid alternates grants 0, 1, 0, 1.
- Response back-pressure:
  - Stimulus: `i_rsp0_ready` held low for 10 cycles.
  - Required: `o_rsp0_valid` and its data stable, `o_busy`=1, both `o_req*_ready`=0.
  - Required: IDLE one cycle after ready rises.
- Reset mid-FEED:
  - Stimulus: assert `i_rst` at T+2.
  - Required: next cycle all outputs are 0, no response is ever issued, and a subsequent req1 is processed normally.
- `PIPE=1`:
  - Stimulus: same vector as the first test.
  - Required: identical result with `o_rsp0_valid` at T+6.
- Stray signals:
  - Stimulus: `i_rsp1_ready` pulsed during a req0 RESP, and `i_req1_valid` dropped before ready.
  - Required: neither has any effect.
